// File: rtl/updown_counter_pkg.sv
// Shared types and helpers for the up/down counter and its prescaler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package updown_counter_pkg;

   // Counter control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the prescaler phase counter. A divide-by-1 prescaler still
   // gets a 1-bit register so the vector is never zero-width.
   function automatic int presc_width(input int prescale);
      return (prescale <= 1) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Clock-enable divider: one tick per PRESCALE enabled cycles.
// Latency: tick is combinational from en and the registered phase; phase updates next edge.
// Backpressure: en low freezes the phase, so counting resumes at the exact same point.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (phase -> 0)
//   restart  synchronous phase restart (phase -> 0)
//   en       advance the phase this cycle
//   tick     high on the enabled cycle that completes a PRESCALE period
module cnt_prescaler
   import updown_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic en,
   output logic tick
);

   localparam int            PW   = presc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;

   // With PRESCALE=1 LAST is 0 and phase never leaves 0, so tick == en.
   assign tick = en && (phase == LAST);

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         phase <= '0;
      end else if (en) begin
         phase <= tick ? '0 : phase + 1'b1;
      end
   end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with modulus, prescale, parallel load and free-run/one-shot FSM.
// Latency: all outputs registered; start at edge N gives busy after N, first step at N+PRESCALE.
// Backpressure: en low freezes count and prescaler phase; no valid/ready handshake.
//
// Optional feature macro: UPDOWN_COUNTER_SAT_EN (adds the sat input; sat=1 holds at terminal
// instead of wrapping). Without it the counter always wraps.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, up              count enable, direction (1 = up)
//   start, clear        enter RUN from IDLE/DONE; synchronous clear to IDLE / count 0
//   load, load_val      parallel load (clamped to MAX)
//   oneshot, [sat]      stop in DONE at terminal; [hold at terminal while free-running]
//   count, tc           registered count; one-cycle terminal-count pulse
//   busy, done          state == RUN; state == DONE
module updown_counter
   import updown_counter_pkg::*;
#(
   parameter int          WIDTH    = 4,
   parameter int unsigned MAX      = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1),
   parameter int          PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             start,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             oneshot,
`ifdef UPDOWN_COUNTER_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

   state_t           state;
   logic             start_acc;
   logic             presc_en;
   logic             tick;
   logic             step;
   logic             at_term;
   logic             sat_hold;
   logic [WIDTH-1:0] load_clamped;

`ifdef UPDOWN_COUNTER_SAT_EN
   assign sat_hold = sat;
`else
   assign sat_hold = 1'b0;
`endif

   assign start_acc    = start && (state != RUN);
   assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

   // Load and clear take the edge, so the prescaler must not advance on those cycles.
   assign presc_en = (state == RUN) && en && !load && !clear;
   assign step     = tick;
   assign at_term  = up ? (count == MAX_V) : (count == '0);

   cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .clk     (clk),
      .rst     (rst),
      .restart (clear || start_acc),
      .en      (presc_en),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state <= IDLE;
         count <= '0;
         tc    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         tc <= 1'b0;

         if (load) begin
            count <= load_clamped;
         end

         if (start_acc) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
         end

         // step implies RUN and no load, so it never collides with the branches above.
         if (step) begin
            if (at_term) begin
               tc <= 1'b1;
               if (oneshot) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (!sat_hold) begin
                  count <= up ? '0 : MAX_V;
               end
            end else begin
               count <= up ? count + 1'b1 : count - 1'b1;
            end
         end
      end
   end

endmodule
